// File: rtl/aes_dec_round_ctrl.sv
// ============================================================================
// aes_dec_round_ctrl
// ----------------------------------------------------------------------------
// Iterative AES decryption sequencer. A single external inverse_round
// datapath is reused for all NUM_OF_ROUNDS rounds. This block:
//   - performs the initial AddRoundKey (round key NUM_OF_ROUNDS),
//   - presents state / round key / last-round flag to the shared round,
//   - captures the round result each cycle,
//   - holds the finished plaintext on a valid/ready output.
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous active-low reset
//   in_valid    cyphertext block offered
//   in_ready    controller idle, can accept a block
//   cyphertext  block to decrypt
//   round_keys  flat expanded key, round key 0 in the most significant slice
//   rnd_state   state presented to inverse_round
//   rnd_key     round key presented to inverse_round
//   rnd_last    final round (inverse_round skips InvMixColumns)
//   rnd_result  combinational result from inverse_round
//   out_valid   plaintext valid
//   out_ready   consumer accepts plaintext
//   plaintext   decrypted block (registered)
//   busy        block in flight
//   blk_count   completed-block counter
//
// Build option:
//   AES_DEC_CTRL_BLK_CNT_EN  when defined, blk_count is a 32-bit wrapping
//                            counter of output handshakes; otherwise it is
//                            tied to zero and no counter flops exist.
// ============================================================================
module aes_dec_round_ctrl #(
    parameter int DATA_WIDTH           = 128,
    parameter int NUM_OF_ROUNDS        = 10,
    parameter int EXPANSIONED_KEY_SIZE = DATA_WIDTH * (NUM_OF_ROUNDS + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH-1:0]           cyphertext,
    input  logic [EXPANSIONED_KEY_SIZE-1:0] round_keys,
    output logic [DATA_WIDTH-1:0]           rnd_state,
    output logic [DATA_WIDTH-1:0]           rnd_key,
    output logic                            rnd_last,
    input  logic [DATA_WIDTH-1:0]           rnd_result,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           plaintext,
    output logic                            busy,
    output logic [31:0]                     blk_count
);

    localparam int CNT_W = $clog2(NUM_OF_ROUNDS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    fsm_t                  r_fsm;
    logic [DATA_WIDTH-1:0] r_state_q;
    logic [CNT_W-1:0]      r_rnd_cnt;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_busy;
    logic                  r_rnd_last;

    logic [DATA_WIDTH-1:0] w_round_key [NUM_OF_ROUNDS+1];
    logic [DATA_WIDTH-1:0] w_sel_key;

    // Slice the flat key bus into individual round keys.
    genvar gi;
    generate
        for (gi = 0; gi <= NUM_OF_ROUNDS; gi++) begin : g_key_slice
            assign w_round_key[gi] =
                round_keys[EXPANSIONED_KEY_SIZE-1-gi*DATA_WIDTH -: DATA_WIDTH];
        end
    endgenerate

    // Round-key mux. The counter rests at 0 outside ROUND, so key 0 is
    // presented there without any extra state qualification.
    always_comb begin
        w_sel_key = w_round_key[0];
        for (int i = 1; i <= NUM_OF_ROUNDS; i++) begin
            if (r_rnd_cnt == CNT_W'(i)) begin
                w_sel_key = w_round_key[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fsm       <= IDLE;
            r_state_q   <= '0;
            r_rnd_cnt   <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_rnd_last  <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid) begin
                        // Initial AddRoundKey uses the last round key.
                        r_state_q  <= cyphertext ^ w_round_key[NUM_OF_ROUNDS];
                        r_rnd_cnt  <= CNT_W'(NUM_OF_ROUNDS - 1);
                        r_rnd_last <= (NUM_OF_ROUNDS == 1);
                        r_fsm      <= ROUND;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ROUND: begin
                    r_state_q <= rnd_result;
                    if (r_rnd_cnt == '0) begin
                        r_fsm       <= DONE;
                        r_out_valid <= 1'b1;
                        r_rnd_last  <= 1'b0;
                    end else begin
                        r_rnd_cnt  <= r_rnd_cnt - CNT_W'(1);
                        // Flag is registered, so raise it one cycle early.
                        r_rnd_last <= (r_rnd_cnt == CNT_W'(1));
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_fsm       <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_fsm <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign rnd_state = r_state_q;
    assign rnd_key   = w_sel_key;
    assign rnd_last  = r_rnd_last;
    assign plaintext = r_state_q;

`ifdef AES_DEC_CTRL_BLK_CNT_EN
    logic [31:0] r_blk_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_blk_count <= '0;
        end else if (r_out_valid && out_ready) begin
            r_blk_count <= r_blk_count + 32'd1;
        end
    end

    assign blk_count = r_blk_count;
`else
    assign blk_count = 32'h0;
`endif

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// ============================================================================
// tb_aes_dec_round_ctrl
// ----------------------------------------------------------------------------
// Directed bench for aes_dec_round_ctrl. A behavioural inverse_round and
// AES-128 key expansion stand in for the external datapath; plaintexts are
// the published FIPS-197 values.
// ============================================================================
module tb_aes_dec_round_ctrl;

    localparam int DW  = 128;
    localparam int NR  = 10;
    localparam int EKS = DW * (NR + 1);

`ifdef AES_DEC_CTRL_BLK_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] IST1 = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [DW-1:0]  cyphertext = '0;
    logic [EKS-1:0] round_keys = '0;
    logic           in_ready;
    logic [DW-1:0]  rnd_state;
    logic [DW-1:0]  rnd_key;
    logic           rnd_last;
    logic [DW-1:0]  rnd_result;
    logic           out_valid;
    logic [DW-1:0]  plaintext;
    logic           busy;
    logic [31:0]    blk_count;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_q[$];

    logic [7:0]     sbox     [256];
    logic [7:0]     inv_sbox [256];
    logic [EKS-1:0] keys1;
    logic [EKS-1:0] keys2;

    always #5 clk = ~clk;

    aes_dec_round_ctrl #(
        .DATA_WIDTH(DW),
        .NUM_OF_ROUNDS(NR),
        .EXPANSIONED_KEY_SIZE(EKS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .cyphertext(cyphertext),
        .round_keys(round_keys),
        .rnd_state(rnd_state),
        .rnd_key(rnd_key),
        .rnd_last(rnd_last),
        .rnd_result(rnd_result),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .plaintext(plaintext),
        .busy(busy),
        .blk_count(blk_count)
    );

    // Cycle counter and input-handshake log (edge index of each accept).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst && in_valid && in_ready) acc_q.push_back(cyc);
    end

    // ---------------- AES reference arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] b;
            logic [7:0] s;
            b = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            end
            s = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
            sbox[x]  = s;
            inv_sbox[s] = 8'(x);
        end
    endtask

    function automatic logic [EKS-1:0] expand_key(input logic [127:0] key);
        logic [31:0]    w [44];
        logic [31:0]    t;
        logic [7:0]     rcon;
        logic [EKS-1:0] r;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
                t[31:24] = t[31:24] ^ rcon;
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        r = '0;
        for (int i = 0; i < 44; i++) r[EKS-1-32*i -: 32] = w[i];
        return r;
    endfunction

    function automatic logic [DW-1:0] rk(input logic [EKS-1:0] bus, input int i);
        return bus[EKS-1-i*DW -: DW];
    endfunction

    // InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
    function automatic logic [127:0] inv_round(input logic [127:0] st,
                                               input logic [127:0] k,
                                               input logic last);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   c0, c1, c2, c3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = st[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                b[rr+4*c] = inv_sbox[a[rr+4*((c-rr+4)%4)]];
        for (int i = 0; i < 16; i++) b[i] = b[i] ^ k[127-8*i -: 8];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                c0 = b[4*c]; c1 = b[4*c+1]; c2 = b[4*c+2]; c3 = b[4*c+3];
                b[4*c]   = gmul(c0,8'h0e) ^ gmul(c1,8'h0b) ^ gmul(c2,8'h0d) ^ gmul(c3,8'h09);
                b[4*c+1] = gmul(c0,8'h09) ^ gmul(c1,8'h0e) ^ gmul(c2,8'h0b) ^ gmul(c3,8'h0d);
                b[4*c+2] = gmul(c0,8'h0d) ^ gmul(c1,8'h09) ^ gmul(c2,8'h0e) ^ gmul(c3,8'h0b);
                b[4*c+3] = gmul(c0,8'h0b) ^ gmul(c1,8'h0d) ^ gmul(c2,8'h09) ^ gmul(c3,8'h0e);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
        return r;
    endfunction

    always_comb rnd_result = inv_round(rnd_state, rnd_key, rnd_last);

    // ---------------- bench helpers ----------------
    task automatic check_value(input string tag, input logic [127:0] obs,
                               input logic [127:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller raises in_valid; returns just after the accepting edge.
    task automatic wait_accept();
        int k;
        k = 0;
        while (!in_ready && k < 40) begin
            tick();
            k++;
        end
        check_value("accept_timeout", 128'(k >= 40), 128'(0));
        tick();
    endtask

    initial begin
        int spacing;
        build_tables();
        keys1 = expand_key(KEY1);
        keys2 = expand_key(KEY2);
        round_keys = keys1;

        // ---- reset state ----
        repeat (3) tick();
        check_value("rst_in_ready",  128'(in_ready),  128'(1));
        check_value("rst_out_valid", 128'(out_valid), 128'(0));
        check_value("rst_busy",      128'(busy),      128'(0));
        check_value("rst_plaintext", plaintext,       128'(0));
        check_value("rst_rnd_state", rnd_state,       128'(0));
        check_value("rst_rnd_key",   rnd_key,         rk(keys1, 0));
        check_value("rst_rnd_last",  128'(rnd_last),  128'(0));
        check_value("rst_blk_count", 128'(blk_count), 128'(0));
        rst = 1'b1;
        tick();

        // ---- FIPS-197 C.1, round sequencing, latency ----
        cyphertext = CT1;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        for (int k = 0; k < NR; k++) begin
            if (k == 0) check_value("c1_first_state", rnd_state, IST1);
            check_value("c1_rnd_key",   rnd_key,              rk(keys1, NR-1-k));
            check_value("c1_rnd_last",  128'(rnd_last),       128'(k == NR-1));
            check_value("c1_out_valid_early", 128'(out_valid), 128'(0));
            check_value("c1_in_ready_busy",   128'(in_ready),  128'(0));
            tick();
        end
        check_value("c1_out_valid", 128'(out_valid), 128'(1));
        check_value("c1_plaintext", plaintext,       PT1);
        tick();
        check_value("c1_idle_out_valid", 128'(out_valid), 128'(0));
        check_value("c1_idle_in_ready",  128'(in_ready),  128'(1));

        // ---- back-to-back, two blocks, second under a different key ----
        acc_q.delete();
        in_valid = 1'b1;
        wait_accept();
        cyphertext = CT2;
        for (int k = 0; k <= NR; k++) begin
            check_value("b2b_in_ready_blk1", 128'(in_ready), 128'(0));
            if (k == NR) begin
                check_value("b2b_out_valid1", 128'(out_valid), 128'(1));
                check_value("b2b_plaintext1", plaintext,       PT1);
            end
            tick();
        end
        round_keys = keys2;
        check_value("b2b_gap_in_ready", 128'(in_ready), 128'(1));
        tick();
        in_valid = 1'b0;
        for (int k = 0; k <= NR; k++) begin
            check_value("b2b_in_ready_blk2", 128'(in_ready), 128'(0));
            if (k == NR) begin
                check_value("b2b_out_valid2", 128'(out_valid), 128'(1));
                check_value("b2b_plaintext2", plaintext,       PT2);
            end
            tick();
        end
        spacing = (acc_q.size() >= 2) ? (acc_q[1] - acc_q[0]) : -1;
        check_value("b2b_accept_spacing", 128'(spacing), 128'(NR + 2));
        check_value("b2b_accept_count",   128'(acc_q.size()), 128'(2));

        // ---- backpressure, with ignored in_valid while busy ----
        round_keys = keys1;
        cyphertext = CT1;
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        wait_accept();
        cyphertext = CT2;
        repeat (NR) tick();
        for (int k = 0; k < 20; k++) begin
            check_value("bp_out_valid", 128'(out_valid), 128'(1));
            check_value("bp_plaintext", plaintext,       PT1);
            check_value("bp_in_ready",  128'(in_ready),  128'(0));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_value("bp_release_out_valid", 128'(out_valid), 128'(0));
        check_value("bp_release_in_ready",  128'(in_ready),  128'(1));
        check_value("bp_blk_count", 128'(blk_count), CNT_EN ? 128'(4) : 128'(0));

        // ---- reset in the 5th ROUND cycle ----
        out_ready  = 1'b1;
        cyphertext = CT1;
        in_valid   = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_value("mrst_in_ready",  128'(in_ready),  128'(1));
        check_value("mrst_out_valid", 128'(out_valid), 128'(0));
        check_value("mrst_busy",      128'(busy),      128'(0));
        check_value("mrst_plaintext", plaintext,       128'(0));
        check_value("mrst_blk_count", 128'(blk_count), 128'(0));
        for (int k = 0; k < 15; k++) begin
            tick();
            check_value("mrst_no_output", 128'(out_valid), 128'(0));
        end

        // ---- three completed blocks for the counter ----
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1;
            wait_accept();
            in_valid = 1'b0;
            repeat (NR) tick();
            check_value("cnt_out_valid", 128'(out_valid), 128'(1));
            check_value("cnt_plaintext", plaintext,       PT1);
            tick();
        end
        check_value("cnt_blk_count", 128'(blk_count), CNT_EN ? 128'(3) : 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_dec_round_ctrl.md
Name: aes_dec_round_ctrl

Overview:
- Iterative sequencer for AES decryption. Drives one external inverse_round datapath instance for NUM_OF_ROUNDS cycles, instead of instantiating one round per stage.
- Performs the initial AddRoundKey, selects the round key for each round from the flat expanded-key bus, flags the final round, and holds the result on a valid/ready output.
- Sits between the key expansion block / system interface and a shared inverse_round instance. Used in area-constrained decryption builds.

Parameters:
- DATA_WIDTH, 128, state/block width in bits
- NUM_OF_ROUNDS, 10, AES round count (10/12/14 for AES-128/192/256)
- EXPANSIONED_KEY_SIZE, DATA_WIDTH*(NUM_OF_ROUNDS+1), width of flat round-key bus

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-low reset; sampled only on rising edge of clk
- in_valid  input  1  cyphertext block offered
- in_ready  output  1  controller idle, can accept a block
- cyphertext  input  DATA_WIDTH  block to decrypt
- round_keys  input  EXPANSIONED_KEY_SIZE  expanded key; round key i = round_keys[EXPANSIONED_KEY_SIZE-1-i*DATA_WIDTH -: DATA_WIDTH]
- rnd_state  output  DATA_WIDTH  state fed to inverse_round
- rnd_key  output  DATA_WIDTH  round key fed to inverse_round
- rnd_last  output  1  current round is the final round (no InvMixColumns)
- rnd_result  input  DATA_WIDTH  combinational result of inverse_round
- out_valid  output  1  plaintext valid
- out_ready  input  1  consumer accepts plaintext
- plaintext  output  DATA_WIDTH  decrypted block
- busy  output  1  block in flight (ROUND or DONE)
- blk_count  output  32  completed-block counter (see Optional Feature)

Behaviour:
- States: IDLE, ROUND, DONE. Registers: state_q[DATA_WIDTH], rnd_cnt[$clog2(NUM_OF_ROUNDS+1)], fsm.
- Reset (rst==0 at a rising edge):
  - fsm=IDLE; state_q=0; rnd_cnt=0; blk_count=0.
  - Outputs after reset: in_ready=1, out_valid=0, busy=0, plaintext=0, rnd_state=0, rnd_key=round key 0, rnd_last=0.
  - Reset mid-operation aborts the block; no out_valid is produced for it.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: state_q <= cyphertext ^ round key NUM_OF_ROUNDS; rnd_cnt <= NUM_OF_ROUNDS-1; fsm <= ROUND.
- ROUND:
  - in_ready=0; rnd_state=state_q; rnd_key=round key rnd_cnt; rnd_last=(rnd_cnt==0).
  - Each cycle: state_q <= rnd_result.
  - If rnd_cnt==0, fsm <= DONE; else rnd_cnt <= rnd_cnt-1.
  - Exactly NUM_OF_ROUNDS cycles are spent in ROUND.
- DONE:
  - out_valid=1; plaintext=state_q, held stable while out_ready==0.
  - On out_ready: fsm <= IDLE; blk_count increments.
  - in_ready=0 in DONE, so a new input is never accepted in the same cycle as output consumption.
- Latency: with input handshake at edge T, out_valid is high after edge T+NUM_OF_ROUNDS. With out_ready tied high, throughput is 1 block per NUM_OF_ROUNDS+2 cycles.
- rnd_state/rnd_key/rnd_last are don't-care outside ROUND. Drive rnd_state=state_q and rnd_key=round key 0 there, with rnd_last=0.
- round_keys is not registered and must stay stable from acceptance until DONE exits. Changing it mid-block is a protocol violation with undefined result.
- in_valid while busy is ignored, with no side effects.
- plaintext is registered, with no combinational path from inputs.
- blk_count wraps 0xFFFFFFFF -> 0.

Optional Feature:
- Macro: AES_DEC_CTRL_BLK_CNT_EN.
- Defined: blk_count is a 32-bit register; it increments on each out_valid&&out_ready and clears on reset.
- Undefined: blk_count is tied to 32'h0 and no counter flops exist.

Test Plan:
- FIPS-197 C.1 vector, key 000102030405060708090a0b0c0d0e0f expanded by the bench model, cyphertext 69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1 -> plaintext 00112233445566778899aabbccddeeff; out_valid rises exactly 10 cycles after the accepting edge.
- Round sequencing -> rnd_key equals round key 9,8,...,0 on consecutive ROUND cycles; rnd_last=1 only on the key-0 cycle.
- Back-to-back: in_valid held high with two blocks, out_ready=1 -> second accept occurs 12 cycles after the first; both plaintexts are correct; in_ready=0 throughout busy.
- Backpressure: out_ready=0 for 20 cycles in DONE -> out_valid and plaintext hold stable, in_ready=0; then out_ready=1 for 1 cycle -> IDLE next cycle.
- Reset mid-operation: rst=0 at the 5th ROUND cycle -> next edge gives in_ready=1, out_valid=0, plaintext=0, blk_count=0; no output for the aborted block.
- With AES_DEC_CTRL_BLK_CNT_EN: 3 completed blocks -> blk_count=3. Without it: blk_count=0 always.
